branch_predictor: RTL and testbench

Dynamic branch predictor for the pipelined RV32 core. It consumes the branch resolution produced by the EX-stage comparator and returns a prediction to the IF stage. It is a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. It also generates the EX-stage redirect request and keeps performance counters.

---
 rtl/branch_predictor_pkg.sv | 20 ++
 rtl/sat_ctr2.sv | 22 ++
 rtl/branch_predictor.sv | 130 +++++++++++++
 tb/tb_branch_predictor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared core constants: branch type encodings (also used by the EX comparator)
// and the 2-bit saturating counter state values.
package branch_predictor_pkg;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BLT  = 2'b10;
  localparam logic [1:0] BR_RSVD = 2'b11;

  localparam logic [1:0] CTR_SNT = 2'b00;  // strong not-taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weak not-taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weak taken
  localparam logic [1:0] CTR_ST  = 2'b11;  // strong taken

  // True only for the conditional branch types that train the predictor.
  function automatic logic is_cond_branch(input logic [1:0] br_type);
    return (br_type == BR_BEQ) || (br_type == BR_BLT);
  endfunction

endpackage

// File: rtl/sat_ctr2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_ctr2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // Step one state toward the observed outcome, holding at either end.
  always_comb begin
    ctr_next = ctr;
    case (ctr)
      CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_next = taken ? CTR_ST  : CTR_WT;
      default: ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit counter per entry. Predicts combinationally
// for the fetch PC, trains from EX-stage resolutions, raises the EX redirect
// and keeps branch / misprediction counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_W = 4,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [1:0]      upd_br_type,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     cnt_branch,
  output logic [31:0]     cnt_mispred
);

  localparam int NUM_ENTRIES = 2 ** INDEX_W;
  localparam int TAG_W       = XLEN - INDEX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  logic               valid_r  [NUM_ENTRIES];
  logic [TAG_W-1:0]   tag_r    [NUM_ENTRIES];
  logic [XLEN-1:0]    target_r [NUM_ENTRIES];
  logic [1:0]         ctr_r    [NUM_ENTRIES];
  logic [31:0]        cnt_branch_r;
  logic [31:0]        cnt_mispred_r;

  logic [INDEX_W-1:0] if_idx_s;
  logic [TAG_W-1:0]   if_tag_s;
  logic               if_hit_s;
  logic [INDEX_W-1:0] upd_idx_s;
  logic [TAG_W-1:0]   upd_tag_s;
  logic               upd_hit_s;
  logic               is_br_s;
  logic               actual_taken_s;
  logic               redirect_s;
  logic [1:0]         ctr_next_s;

  assign if_idx_s  = if_pc[INDEX_W+1:2];
  assign if_tag_s  = if_pc[XLEN-1:INDEX_W+2];
  assign upd_idx_s = upd_pc[INDEX_W+1:2];
  assign upd_tag_s = upd_pc[XLEN-1:INDEX_W+2];

  assign if_hit_s  = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s);
  assign upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);

  // Only BEQ/BLT train; anything else resolves as not-taken.
  assign is_br_s        = upd_valid && is_cond_branch(upd_br_type);
  assign actual_taken_s = is_br_s && upd_taken;

  sat_ctr2 u_sat_ctr2 (
    .ctr      (ctr_r[upd_idx_s]),
    .taken    (upd_taken),
    .ctr_next (ctr_next_s)
  );

  // Fetch prediction from pre-update state; taken only on a hit leaning taken.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = if_pc + PC_STEP;
    if (if_hit_s && ctr_r[if_idx_s][1]) begin
      pred_taken  = 1'b1;
      pred_target = target_r[if_idx_s];
    end else begin
      pred_taken  = 1'b0;
      pred_target = if_pc + PC_STEP;
    end
  end

  // Redirect on a direction mismatch or a wrong target for a correctly-taken branch.
  always_comb begin
    redirect_s  = 1'b0;
    redirect_pc = upd_pc + PC_STEP;
    if (upd_valid) begin
      redirect_s = (actual_taken_s != upd_pred_taken) ||
                   (actual_taken_s && upd_pred_taken && (upd_target != upd_pred_target));
      redirect_pc = actual_taken_s ? upd_target : (upd_pc + PC_STEP);
    end else begin
      redirect_s  = 1'b0;
      redirect_pc = upd_pc + PC_STEP;
    end
  end

  assign redirect    = redirect_s;
  assign cnt_branch  = cnt_branch_r;
  assign cnt_mispred = cnt_mispred_r;

  // Train the BTB entry and the performance counters on each conditional branch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= '0;
        ctr_r[i]    <= CTR_WNT;
      end
      cnt_branch_r  <= 32'd0;
      cnt_mispred_r <= 32'd0;
    end else if (is_br_s) begin
      cnt_branch_r <= cnt_branch_r + 32'd1;
      if (redirect_s) begin
        cnt_mispred_r <= cnt_mispred_r + 32'd1;
      end
      if (upd_hit_s) begin
        ctr_r[upd_idx_s] <= ctr_next_s;
        if (upd_taken) begin
          target_r[upd_idx_s] <= upd_target;
        end
      end else if (upd_taken) begin
        // Miss on a taken branch allocates, evicting any aliasing entry.
        valid_r[upd_idx_s]  <= 1'b1;
        tag_r[upd_idx_s]    <= upd_tag_s;
        target_r[upd_idx_s] <= upd_target;
        ctr_r[upd_idx_s]    <= CTR_WT;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a driver issues one instruction per
// cycle and queues the reference model's expected outputs; a monitor on the
// falling edge pops and compares.
module tb_branch_predictor;

  localparam int INDEX_W = 4;
  localparam int XLEN    = 32;
  localparam int NENT    = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [XLEN-1:0] if_pc = '0;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid = 1'b0;
  logic [XLEN-1:0] upd_pc = '0;
  logic [1:0]      upd_br_type = 2'b00;
  logic            upd_taken = 1'b0;
  logic [XLEN-1:0] upd_target = '0;
  logic            upd_pred_taken = 1'b0;
  logic [XLEN-1:0] upd_pred_target = '0;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     cnt_branch;
  logic [31:0]     cnt_mispred;

  branch_predictor #(.INDEX_W(INDEX_W), .XLEN(XLEN)) dut (
    .clk(clk), .rstn(rstn), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_br_type(upd_br_type),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pt;
    logic [31:0] ptg;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] cb;
    logic [31:0] cm;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a table of entries keyed by index, counters as 0..3 integers.
  bit          m_valid  [NENT];
  logic [31:0] m_tag    [NENT];
  logic [31:0] m_target [NENT];
  int          m_ctr    [NENT];
  logic [31:0] m_cb, m_cm;

  function automatic void model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 1;
    end
    m_cb = '0; m_cm = '0;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i;
    i = idx_of(pc);
    if (m_valid[i] && m_tag[i] == (pc >> (INDEX_W + 2)) && m_ctr[i] >= 2) begin
      t = 1'b1; tg = m_target[i];
    end else begin
      t = 1'b0; tg = pc + 32'd4;
    end
  endfunction

  function automatic void chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
    end
  endfunction

  // Expected outputs for the currently driven inputs, then advance the model past the edge.
  function automatic void issue(input string nm);
    exp_t e;
    logic is_br, act;
    int i;
    model_predict(if_pc, e.pt, e.ptg);
    is_br = upd_valid && (upd_br_type == 2'd1 || upd_br_type == 2'd2);
    act   = is_br && upd_taken;
    e.rd  = upd_valid && ((act != upd_pred_taken) ||
                          (act && upd_pred_taken && upd_target != upd_pred_target));
    e.rpc = act ? upd_target : upd_pc + 32'd4;
    e.cb  = m_cb;
    e.cm  = m_cm;
    e.nm  = nm;
    sb_q.push_back(e);
    if (is_br && rstn) begin
      m_cb = m_cb + 32'd1;
      if (e.rd) m_cm = m_cm + 32'd1;
      i = idx_of(upd_pc);
      if (m_valid[i] && m_tag[i] == (upd_pc >> (INDEX_W + 2))) begin
        m_ctr[i] = upd_taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                             : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (upd_taken) m_target[i] = upd_target;
      end else if (upd_taken) begin
        m_valid[i] = 1'b1; m_tag[i] = upd_pc >> (INDEX_W + 2);
        m_target[i] = upd_target; m_ctr[i] = 2;
      end
    end
  endfunction

  task automatic drive(input logic [31:0] ipc, input logic v, input logic [31:0] pc,
                       input logic [1:0] bt, input logic tk, input logic [31:0] tg,
                       input logic ppt, input logic [31:0] pptg, input string nm);
    @(posedge clk); #1;
    if_pc = ipc; upd_valid = v; upd_pc = pc; upd_br_type = bt;
    upd_taken = tk; upd_target = tg; upd_pred_taken = ppt; upd_pred_target = pptg;
    issue(nm);
  endtask

  task automatic idle(input logic [31:0] ipc, input string nm);
    drive(ipc, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, nm);
  endtask

  // Monitor: compare every queued expectation against the DUT away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.nm, "pred_taken",  {31'd0, pred_taken}, {31'd0, e.pt});
        chk(e.nm, "pred_target", pred_target, e.ptg);
        chk(e.nm, "redirect",    {31'd0, redirect}, {31'd0, e.rd});
        chk(e.nm, "redirect_pc", redirect_pc, e.rpc);
        chk(e.nm, "cnt_branch",  cnt_branch, e.cb);
        chk(e.nm, "cnt_mispred", cnt_mispred, e.cm);
      end
    end
  end

  initial begin
    logic        ppt;
    logic [31:0] pptg, pc, ipc;
    int          wait_cnt;

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;

    // Directed walk through the main scenarios.
    idle(32'h100, "reset_state");
    drive(32'h100, 1'b1, 32'h100, 2'b01, 1'b1, 32'h80, 1'b0, 32'h104, "beq_first_taken");
    idle(32'h100, "predict_after_alloc");
    for (int k = 0; k < 4; k++)
      drive(32'h100, 1'b1, 32'h100, 2'b01, 1'b1, 32'h80, 1'b1, 32'h80, "beq_taken_sat");
    drive(32'h100, 1'b1, 32'h100, 2'b01, 1'b0, 32'h80, 1'b1, 32'h80, "beq_not_taken");
    idle(32'h100, "still_taken");
    drive(32'h100, 1'b1, 32'h140, 2'b10, 1'b1, 32'h200, 1'b0, 32'h144, "blt_alias");
    idle(32'h100, "alias_evicted");
    idle(32'h140, "alias_new");
    drive(32'h140, 1'b1, 32'h180, 2'b00, 1'b0, 32'h0, 1'b1, 32'h300, "nonbranch_pred_t");
    drive(32'h140, 1'b1, 32'h1C0, 2'b11, 1'b1, 32'h400, 1'b0, 32'h1C4, "reserved_type");
    idle(32'h1C0, "reserved_no_alloc");
    drive(32'h140, 1'b1, 32'h140, 2'b10, 1'b1, 32'h240, 1'b1, 32'h200, "target_change");
    idle(32'h140, "new_target");

    // Reset asserted between edges with an update pending.
    @(posedge clk); #1;
    if_pc = 32'h140; upd_valid = 1'b1; upd_pc = 32'h140; upd_br_type = 2'b10;
    upd_taken = 1'b1; upd_target = 32'h500; upd_pred_taken = 1'b1; upd_pred_target = 32'h240;
    #2;
    rstn = 1'b0; upd_valid = 1'b0;
    model_reset();
    issue("reset_mid");
    @(negedge clk); #1; rstn = 1'b1;
    idle(32'h140, "after_reset");

    // Randomized traffic over a small PC pool so hits, aliases and saturation all occur.
    for (int n = 0; n < 1500; n++) begin
      pc  = 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2);
      ipc = 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2);
      model_predict(pc, ppt, pptg);
      if ($urandom_range(0, 9) == 0) begin
        ppt  = 1'($urandom_range(0, 1));
        pptg = 32'h2000 + ($urandom_range(0, 7) << 2);
      end
      drive(ipc, ($urandom_range(0, 9) < 8), pc, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 32'h2000 + ($urandom_range(0, 7) << 2),
            ppt, pptg, "random");
    end
    idle(32'h1000, "final_counts");

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 100) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
